// File: rtl/hex_byte_decoder.sv
// hex_byte_decoder
//   Turns an ASCII hex character stream (from uart_rx) into binary bytes.
//   Pairs of hex digits form one byte, which is queued in a small
//   first-word-fall-through FIFO and handed to a consumer over valid/ready.
//   CR/LF produce a line_end pulse; malformed characters or broken pairs
//   produce an err pulse. A byte dropped on a full FIFO sets a sticky
//   overflow flag that only RST clears.
//
// Ports
//   CLK, RST      clock; synchronous active-high reset
//   rx_valid      one-cycle strobe qualifying rx_data
//   rx_data       received ASCII character
//   out_valid     FIFO non-empty; out_data holds the oldest byte
//   out_data      oldest decoded byte, 0 when out_valid=0
//   out_ready     consumer accepts out_data when out_valid & out_ready
//   line_end      one-cycle pulse after a CR or LF
//   err           one-cycle pulse after a malformed character/sequence
//   overflow      sticky: a decoded byte was dropped on a full FIFO
//   fifo_count    number of bytes currently buffered
module hex_byte_decoder #(
    parameter  int FIFO_DEPTH = 8,
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             line_end,
    output logic             err,
    output logic             overflow,
    output logic [PTR_W:0]   fifo_count
);

    typedef enum logic {S_HI, S_LO} state_t;

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // ---------------- character classification ----------------
    logic       is_dig;
    logic [3:0] dig_val;
    logic       is_space;
    logic       is_eol;

    always_comb begin
        is_dig  = 1'b0;
        dig_val = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_dig  = 1'b1;
            dig_val = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 lands on 10..15
            is_dig  = 1'b1;
            dig_val = rx_data[3:0] + 4'd9;
        end
    end

    assign is_space = (rx_data == 8'h20) || (rx_data == 8'h09);
    assign is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);

    // ---------------- parser FSM ----------------
    state_t     state_q, state_d;
    logic [3:0] nib_q, nib_d;
    logic       push;
    logic [7:0] push_data;
    logic       err_d, eol_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_HI;
            nib_q    <= 4'd0;
            err      <= 1'b0;
            line_end <= 1'b0;
        end else begin
            state_q  <= state_d;
            nib_q    <= nib_d;
            err      <= err_d;
            line_end <= eol_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        nib_d     = nib_q;
        push      = 1'b0;
        push_data = {nib_q, dig_val};
        err_d     = 1'b0;
        eol_d     = 1'b0;
        if (rx_valid) begin
            case (state_q)
                S_HI: begin
                    if (is_dig) begin
                        nib_d   = dig_val;
                        state_d = S_LO;
                    end else if (is_eol) begin
                        eol_d = 1'b1;
                    end else if (!is_space) begin
                        err_d = 1'b1;
                    end
                end
                S_LO: begin
                    // Any character completes or aborts the pair.
                    state_d = S_HI;
                    nib_d   = 4'd0;
                    if (is_dig) begin
                        push = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        eol_d = is_eol;
                    end
                end
                default: state_d = S_HI;
            endcase
        end
    end

    // ---------------- FWFT FIFO ----------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, empty, pop, wr_en, drop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign pop   = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    assign out_valid  = !empty;
    assign out_data   = empty ? 8'h00 : mem[rd_ptr];
    assign fifo_count = count;

endmodule
